// File: rtl/coeff_load_arbiter.sv
// Burst arbiter in front of the coefficient buffer write port: grants whole bursts and
// issues them word by word. Define COEFF_ARB_FIXED_PRIO_EN for fixed-priority selection.
module coeff_load_arbiter #(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned ADDR_WIDTH  = 5,
  parameter int unsigned COEFF_WIDTH = 16,
  parameter int unsigned TIMEOUT     = 64,
  parameter int unsigned ID_WIDTH    = 3
) (
  input  logic                              axi_clk,
  input  logic                              axi_rst,
  input  logic [NUM_REQ-1:0]                req_valid_i,
  input  logic [NUM_REQ-1:0]                req_last_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]     req_addr_i,
  input  logic [NUM_REQ*2*COEFF_WIDTH-1:0]  req_data_i,
  output logic [NUM_REQ-1:0]                req_ready_o,
  output logic [NUM_REQ-1:0]                grant_o,
  output logic                              busy_o,
  output logic                              burst_done_o,
  output logic                              err_timeout_o,
  output logic [ID_WIDTH-1:0]               err_req_id_o,
  input  logic                              err_clr_i,
  output logic [ADDR_WIDTH-1:0]             axi_addr,
  output logic [2*COEFF_WIDTH-1:0]          axi_data_w,
  output logic                              axi_we,
  input  logic                              axi_ack
);

  localparam int unsigned DATA_W = 2 * COEFF_WIDTH;
  localparam int unsigned CNT_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_ACK
  } state_t;

  state_t                r_state;
  logic [NUM_REQ-1:0]    r_grant;
  logic [ID_WIDTH-1:0]   r_gidx;
  logic                  r_busy;
  logic                  r_we;
  logic                  r_done;
  logic                  r_last;
  logic                  r_err;
  logic [ID_WIDTH-1:0]   r_err_id;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_W-1:0]     r_data;
  logic [CNT_W-1:0]      r_cnt;

`ifndef COEFF_ARB_FIXED_PRIO_EN
  logic [ID_WIDTH-1:0]   r_ptr;
  logic [ID_WIDTH-1:0]   w_ptr_next;
`endif

  logic                  w_any;
  logic [ID_WIDTH-1:0]   w_win_idx;
  int unsigned           w_best;
  int unsigned           w_dist;
  logic                  w_sel_valid;
  logic                  w_sel_last;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_W-1:0]     w_sel_data;
  logic                  w_timeout;

  // Winner = valid requester with the smallest distance from the priority start point
  always_comb begin
    w_any     = 1'b0;
    w_win_idx = '0;
    w_best    = NUM_REQ;
    w_dist    = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (req_valid_i[k]) begin
`ifdef COEFF_ARB_FIXED_PRIO_EN
        w_dist = k;
`else
        w_dist = (k + NUM_REQ - 32'(r_ptr)) % NUM_REQ;
`endif
        if (w_dist < w_best) begin
          w_best    = w_dist;
          w_win_idx = ID_WIDTH'(k);
          w_any     = 1'b1;
        end
      end
    end
  end

  // Mux the granted requester's word onto the capture path
  always_comb begin
    w_sel_valid = |(req_valid_i & r_grant);
    w_sel_last  = |(req_last_i & r_grant);
    w_sel_addr  = '0;
    w_sel_data  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (r_grant[k]) begin
        w_sel_addr = req_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        w_sel_data = req_data_i[k*DATA_W +: DATA_W];
      end
    end
  end

  // Abort on the cycle that would bring the wait count to TIMEOUT-1
  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 2));

`ifndef COEFF_ARB_FIXED_PRIO_EN
  assign w_ptr_next = ID_WIDTH'((32'(r_gidx) + 32'd1) % NUM_REQ);
`endif

  always_ff @(posedge axi_clk) begin
    if (axi_rst) begin
      r_state  <= ST_IDLE;
      r_grant  <= '0;
      r_gidx   <= '0;
      r_busy   <= 1'b0;
      r_we     <= 1'b0;
      r_done   <= 1'b0;
      r_last   <= 1'b0;
      r_err    <= 1'b0;
      r_err_id <= '0;
      r_addr   <= '0;
      r_data   <= '0;
      r_cnt    <= '0;
`ifndef COEFF_ARB_FIXED_PRIO_EN
      r_ptr    <= '0;
`endif
    end else begin
      r_we   <= 1'b0;
      r_done <= 1'b0;
      // Clear first so a timeout in the same cycle overrides it
      if (err_clr_i) begin
        r_err    <= 1'b0;
        r_err_id <= '0;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_grant <= NUM_REQ'(1) << w_win_idx;
            r_gidx  <= w_win_idx;
            r_busy  <= 1'b1;
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (w_sel_valid) begin
            r_addr  <= w_sel_addr;
            r_data  <= w_sel_data;
            r_last  <= w_sel_last;
            r_we    <= 1'b1;
            r_cnt   <= '0;
            r_state <= ST_WAIT_ACK;
          end
        end
        ST_WAIT_ACK: begin
          if (axi_ack) begin
            if (r_last) begin
              r_done  <= 1'b1;
              r_grant <= '0;
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
`ifndef COEFF_ARB_FIXED_PRIO_EN
              r_ptr   <= w_ptr_next;
`endif
            end else begin
              r_state <= ST_ISSUE;
            end
          end else if (w_timeout) begin
            r_err    <= 1'b1;
            r_err_id <= r_gidx;
            r_grant  <= '0;
            r_busy   <= 1'b0;
            r_state  <= ST_IDLE;
`ifndef COEFF_ARB_FIXED_PRIO_EN
            r_ptr    <= w_ptr_next;
`endif
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_grant <= '0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Ready is a decode of registered state and grant so a word is taken in its first ISSUE cycle
  assign req_ready_o   = (r_state == ST_ISSUE) ? r_grant : '0;
  assign grant_o       = r_grant;
  assign busy_o        = r_busy;
  assign burst_done_o  = r_done;
  assign err_timeout_o = r_err;
  assign err_req_id_o  = r_err_id;
  assign axi_addr      = r_addr;
  assign axi_data_w    = r_data;
  assign axi_we        = r_we;

endmodule

// File: tb/tb_coeff_load_arbiter.sv
// Directed scoreboard bench for coeff_load_arbiter: requester queues feed bursts,
// expected writes are queued in grant order and checked at every axi_we pulse.
module tb_coeff_load_arbiter;

  localparam int NUM_REQ     = 2;
  localparam int ADDR_WIDTH  = 5;
  localparam int COEFF_WIDTH = 16;
  localparam int TIMEOUT     = 8;
  localparam int ID_WIDTH    = 3;
  localparam int DW          = 2 * COEFF_WIDTH;

  logic                         axi_clk;
  logic                         axi_rst;
  logic [NUM_REQ-1:0]           req_valid_i;
  logic [NUM_REQ-1:0]           req_last_i;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i;
  logic [NUM_REQ*DW-1:0]        req_data_i;
  logic [NUM_REQ-1:0]           req_ready_o;
  logic [NUM_REQ-1:0]           grant_o;
  logic                         busy_o;
  logic                         burst_done_o;
  logic                         err_timeout_o;
  logic [ID_WIDTH-1:0]          err_req_id_o;
  logic                         err_clr_i;
  logic [ADDR_WIDTH-1:0]        axi_addr;
  logic [DW-1:0]                axi_data_w;
  logic                         axi_we;
  logic                         axi_ack;

  coeff_load_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_WIDTH(ADDR_WIDTH), .COEFF_WIDTH(COEFF_WIDTH),
    .TIMEOUT(TIMEOUT), .ID_WIDTH(ID_WIDTH)
  ) dut (
    .axi_clk(axi_clk), .axi_rst(axi_rst),
    .req_valid_i(req_valid_i), .req_last_i(req_last_i),
    .req_addr_i(req_addr_i), .req_data_i(req_data_i),
    .req_ready_o(req_ready_o), .grant_o(grant_o), .busy_o(busy_o),
    .burst_done_o(burst_done_o), .err_timeout_o(err_timeout_o),
    .err_req_id_o(err_req_id_o), .err_clr_i(err_clr_i),
    .axi_addr(axi_addr), .axi_data_w(axi_data_w), .axi_we(axi_we), .axi_ack(axi_ack)
  );

  initial axi_clk = 1'b0;
  always #5 axi_clk = ~axi_clk;

  typedef struct {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DW-1:0]         data;
    logic                  last;
    int                    gap;
  } word_t;

  typedef struct {
    int                    owner;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DW-1:0]         data;
  } exp_t;

  word_t word_q [NUM_REQ][$];
  exp_t  exp_q[$];
  int    we_cyc[$];
  int    gap_left [NUM_REQ];
  int    ack_mode;
  logic  we_prev;
  int    cyc;
  int    done_cnt;
  int    done_ref;
  int    checks;
  int    errors;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NUM_REQ-1:0] onehot(input int k);
    return NUM_REQ'(1) << k;
  endfunction

  task automatic drive_reqs();
    for (int k = 0; k < NUM_REQ; k++) begin
      if (word_q[k].size() > 0 && gap_left[k] == 0) begin
        req_valid_i[k] = 1'b1;
        req_last_i[k]  = word_q[k][0].last;
        req_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH] = word_q[k][0].addr;
        req_data_i[k*DW +: DW] = word_q[k][0].data;
      end else begin
        req_valid_i[k] = 1'b0;
        req_last_i[k]  = 1'b0;
      end
    end
  endtask

  // Queue a burst on requester k; optionally record its writes as expected next in order
  task automatic push_burst(input int k, input int addr0, input int seed, input int n,
                            input int stall_idx, input int stall_len, input bit do_exp);
    word_t w;
    exp_t  e;
    for (int i = 0; i < n; i++) begin
      w.addr = ADDR_WIDTH'(addr0 + i);
      w.data = {COEFF_WIDTH'(seed + 2*i + 1), COEFF_WIDTH'(seed + 2*i + 2)};
      w.last = (i == n - 1);
      w.gap  = (i == stall_idx) ? stall_len : 0;
      word_q[k].push_back(w);
      if (do_exp) begin
        e.owner = k;
        e.addr  = w.addr;
        e.data  = w.data;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic monitor();
    exp_t e;
    if (axi_we) begin
      we_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("spurious_we", 64'(axi_we), 64'(0));
      end else begin
        e = exp_q.pop_front();
        check("we_owner", 64'(grant_o), 64'(onehot(e.owner)));
        check("we_addr", 64'(axi_addr), 64'(e.addr));
        check("we_data", 64'(axi_data_w), 64'(e.data));
      end
    end
    if (burst_done_o) done_cnt++;
  endtask

  // One clock: handshakes sampled before the edge, outputs checked 1 time unit after it
  task automatic tick();
    logic [NUM_REQ-1:0] hs;
    @(negedge axi_clk);
    hs = req_valid_i & req_ready_o;
    @(posedge axi_clk);
    #1;
    cyc++;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (hs[k] && word_q[k].size() > 0) begin
        void'(word_q[k].pop_front());
        gap_left[k] = (word_q[k].size() > 0) ? word_q[k][0].gap : 0;
      end else if (gap_left[k] > 0) begin
        gap_left[k]--;
      end
    end
    monitor();
    case (ack_mode)
      0:       axi_ack = axi_we;
      1:       axi_ack = we_prev;
      default: axi_ack = 1'b0;
    endcase
    we_prev = axi_we;
    drive_reqs();
  endtask

  task automatic run_idle(input int max, input string tag);
    int n;
    bit busy_any;
    n = 0;
    do begin
      tick();
      n++;
      busy_any = busy_o || exp_q.size() > 0;
      for (int k = 0; k < NUM_REQ; k++) if (word_q[k].size() > 0) busy_any = 1'b1;
    end while (busy_any && n < max);
    check({tag, "_drained"}, 64'(exp_q.size()), 64'(0));
    check({tag, "_idle"}, 64'(busy_o), 64'(0));
  endtask

  task automatic wait_we(input int max, input string tag);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!axi_we && n < max);
    check({tag, "_we_seen"}, 64'(axi_we), 64'(1));
  endtask

  task automatic do_reset();
    for (int k = 0; k < NUM_REQ; k++) begin
      word_q[k].delete();
      gap_left[k] = 0;
    end
    exp_q.delete();
    drive_reqs();
    axi_rst = 1'b1;
    tick();
    axi_rst = 1'b0;
    we_prev = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_grant"}, 64'(grant_o), 64'(0));
    check({tag, "_busy"}, 64'(busy_o), 64'(0));
    check({tag, "_we"}, 64'(axi_we), 64'(0));
    check({tag, "_ready"}, 64'(req_ready_o), 64'(0));
    check({tag, "_done"}, 64'(burst_done_o), 64'(0));
    check({tag, "_addr"}, 64'(axi_addr), 64'(0));
    check({tag, "_data"}, 64'(axi_data_w), 64'(0));
    check({tag, "_err"}, 64'(err_timeout_o), 64'(0));
    check({tag, "_err_id"}, 64'(err_req_id_o), 64'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; errors = 0; cyc = 0; done_cnt = 0;
    ack_mode = 1; we_prev = 1'b0;
    axi_rst = 1'b1; err_clr_i = 1'b0; axi_ack = 1'b0;
    req_valid_i = '0; req_last_i = '0; req_addr_i = '0; req_data_i = '0;
    for (int k = 0; k < NUM_REQ; k++) gap_left[k] = 0;

    // Reset state
    tick(); tick();
    axi_rst = 1'b0;
    check_all_zero("reset");

    // Single 3-word burst from req0, ack one cycle after each write
    done_ref = done_cnt;
    push_burst(0, 0, 0, 3, -1, 0, 1'b1);
    drive_reqs();
    tick();
    check("single_first_grant", 64'(grant_o), 64'(2'b01));
    check("single_busy", 64'(busy_o), 64'(1));
    run_idle(100, "single");
    check("single_done_count", 64'(done_cnt - done_ref), 64'(1));
    check("single_grant_clear", 64'(grant_o), 64'(0));

    // Contention twice after reset: req0 then req1 both times
    do_reset();
    done_ref = done_cnt;
    push_burst(0, 8, 16, 2, -1, 0, 1'b1);
    push_burst(1, 16, 32, 2, -1, 0, 1'b1);
    drive_reqs();
    tick();
    check("contend1_grant", 64'(grant_o), 64'(2'b01));
    run_idle(100, "contend1");
    push_burst(0, 10, 48, 2, -1, 0, 1'b1);
    push_burst(1, 18, 64, 2, -1, 0, 1'b1);
    drive_reqs();
    tick();
    check("contend2_grant", 64'(grant_o), 64'(2'b01));
    run_idle(100, "contend2");
    check("contend_done_count", 64'(done_cnt - done_ref), 64'(4));

    // Burst lock: req0 stalls mid-burst while req1 is waiting
    push_burst(0, 4, 80, 3, 1, 7, 1'b1);
    drive_reqs();
    tick();
    check("lock_first_grant", 64'(grant_o), 64'(2'b01));
    push_burst(1, 20, 96, 2, -1, 0, 1'b1);
    drive_reqs();
    for (int n = 0; n < 60 && word_q[0].size() > 0; n++) begin
      tick();
      check("lock_grant", 64'(grant_o), 64'(2'b01));
      check("lock_ready1", 64'(req_ready_o[1]), 64'(0));
    end
    run_idle(100, "lock");

    // Timeout on req1, then its remaining word completes as a new burst
    done_ref = done_cnt;
    ack_mode = 2;
    push_burst(1, 26, 128, 2, -1, 0, 1'b1);
    drive_reqs();
    wait_we(20, "to1");
    for (int i = 1; i < TIMEOUT - 1; i++) begin
      tick();
      check("to1_pending", 64'(err_timeout_o), 64'(0));
    end
    tick();
    check("to1_flag", 64'(err_timeout_o), 64'(1));
    check("to1_id", 64'(err_req_id_o), 64'(1));
    check("to1_idle", 64'(busy_o), 64'(0));
    check("to1_grant", 64'(grant_o), 64'(0));
    ack_mode = 1;
    run_idle(100, "to1_rest");
    check("to1_sticky", 64'(err_timeout_o), 64'(1));
    check("to1_done_count", 64'(done_cnt - done_ref), 64'(1));
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
    check("clr_flag", 64'(err_timeout_o), 64'(0));
    check("clr_id", 64'(err_req_id_o), 64'(0));

    // Second timeout on req0 with err_clr_i in the same cycle: set wins
    ack_mode = 2;
    push_burst(0, 30, 160, 1, -1, 0, 1'b1);
    drive_reqs();
    wait_we(20, "to2");
    for (int i = 1; i < TIMEOUT - 1; i++) begin
      tick();
      check("to2_pending", 64'(err_timeout_o), 64'(0));
    end
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
    check("to2_set_wins", 64'(err_timeout_o), 64'(1));
    check("to2_id", 64'(err_req_id_o), 64'(0));
    ack_mode = 1;
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
    check("to2_cleared", 64'(err_timeout_o), 64'(0));

    // Reset while in WAIT_ACK; req1 would win without the pointer reset
    ack_mode = 2;
    push_burst(0, 3, 192, 2, -1, 0, 1'b1);
    drive_reqs();
    wait_we(20, "rst");
    tick();
    do_reset();
    check_all_zero("rst_mid");
    ack_mode = 1;
    for (int i = 0; i < 6; i++) tick();
    check("rst_no_we_count", 64'(exp_q.size()), 64'(0));
    push_burst(0, 12, 224, 1, -1, 0, 1'b1);
    push_burst(1, 13, 240, 1, -1, 0, 1'b1);
    drive_reqs();
    tick();
    check("rst_first_grant", 64'(grant_o), 64'(2'b01));
    run_idle(100, "rst_after");

    // Ack coincident with write strobe: two cycles per word
    ack_mode = 0;
    done_ref = done_cnt;
    we_cyc.delete();
    push_burst(0, 16, 256, 4, -1, 0, 1'b1);
    drive_reqs();
    run_idle(100, "fast");
    check("fast_we_count", 64'(we_cyc.size()), 64'(4));
    if (we_cyc.size() == 4)
      check("fast_span", 64'(we_cyc[3] - we_cyc[0]), 64'(6));
    check("fast_no_timeout", 64'(err_timeout_o), 64'(0));
    check("fast_done_count", 64'(done_cnt - done_ref), 64'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
